// File: rtl/pipe_pkg.sv
// Shared definitions for the writeback result stage.
//   wb_state_t : result stage state encoding
//   REG_AW     : architectural register address width
//   REG_ZERO   : hard-wired zero register; writes to it are suppressed
package pipe_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MDU = 2'd1,
        ST_FULL     = 2'd2
    } wb_state_t;

endpackage

// File: rtl/pri_src_sel.sv
// Combinational priority encoder plus data select for the result sources.
// The lowest set request bit wins; no request bits selects the last source.
// Ports:
//   src_sel  [NSRC]     : per-source request bits
//   src_data [NSRC*DW]  : source i at bits [i*DW +: DW]
//   win_idx  [IW]       : winning source index
//   win_data [DW]       : winning source data
module pri_src_sel #(
    parameter int DW   = 32,
    parameter int NSRC = 4,
    parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]    src_sel,
    input  logic [NSRC*DW-1:0] src_data,
    output logic [IW-1:0]      win_idx,
    output logic [DW-1:0]      win_data
);

    // Scan from the top down so the lowest set bit is the last to overwrite.
    always_comb begin
        win_idx = IW'(NSRC - 1);
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_sel[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    assign win_data = src_data[int'(win_idx)*DW +: DW];

endmodule

// File: rtl/wb_result_stage.sv
// Writeback result stage: selects one of NSRC result sources, waits for the
// multi-cycle unit (MDU) when its result is late, and holds a registered
// writeback bundle until the consumer takes it.
// Optional feature: define WB_RESULT_BYPASS_EN to add the fwd_valid/fwd_data
// forward path toward the ID stage.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid/in_ready          : request handshake
//   in_sel, in_data            : source request bits and packed source data
//   in_waddr, in_wen           : destination register and write enable
//   mdu_valid, mdu_data        : late MDU result strobe and data
//   flush                      : drop held and incoming work
//   out_valid/out_ready        : result handshake
//   out_data, out_waddr, out_wen : registered writeback bundle
//   busy                       : waiting for the MDU
//   stall_cnt                  : saturating count of stalled request cycles
//   fwd_valid, fwd_data        : forward path (WB_RESULT_BYPASS_EN only)
//
// state       | meaning
// ST_IDLE     | empty, ready for a request
// ST_WAIT_MDU | MDU request accepted, result not yet returned
// ST_FULL     | result bundle held, waiting for out_ready
module wb_result_stage
    import pipe_pkg::*;
#(
    parameter int DW      = 32,
    parameter int NSRC    = 4,
    parameter int MDU_IDX = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NSRC-1:0]      in_sel,
    input  logic [NSRC*DW-1:0]   in_data,
    input  logic [REG_AW-1:0]    in_waddr,
    input  logic                 in_wen,
    input  logic                 mdu_valid,
    input  logic [DW-1:0]        mdu_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [REG_AW-1:0]    out_waddr,
    output logic                 out_wen,
    output logic                 busy,
    output logic [15:0]          stall_cnt
`ifdef WB_RESULT_BYPASS_EN
    ,
    output logic                 fwd_valid,
    output logic [DW-1:0]        fwd_data
`endif
);

    localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    wb_state_t          state_q, state_d;
    logic [DW-1:0]      data_q;
    logic [REG_AW-1:0]  waddr_q;
    logic               wen_q;
    logic [15:0]        stall_q;

    logic [IW-1:0]      sel_idx;
    logic [DW-1:0]      sel_data;
    logic               sel_is_mdu;
    logic               accept;
    logic               stall;
    wb_state_t          accept_state;

    pri_src_sel #(
        .DW   (DW),
        .NSRC (NSRC),
        .IW   (IW)
    ) u_pri_src_sel (
        .src_sel  (in_sel),
        .src_data (in_data),
        .win_idx  (sel_idx),
        .win_data (sel_data)
    );

    assign sel_is_mdu = (int'(sel_idx) == MDU_IDX);

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE:     in_ready = 1'b1;
            ST_FULL:     in_ready = out_ready;
            default:     in_ready = 1'b0;
        endcase
    end

    // Flush suppresses the accept but not the stall accounting.
    assign accept = in_valid && in_ready && !flush;
    assign stall  = in_valid && !in_ready;

    // Destination state for an accepted request, shared by IDLE and the
    // back-to-back path out of FULL.
    assign accept_state = (sel_is_mdu && !mdu_valid) ? ST_WAIT_MDU : ST_FULL;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = accept_state;
                end
            end
            ST_WAIT_MDU: begin
                if (mdu_valid) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    state_d = accept ? accept_state : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            waddr_q <= '0;
            wen_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (accept) begin
                waddr_q <= in_waddr;
                // Writes to the zero register are squashed at capture.
                wen_q   <= in_wen && (in_waddr != REG_ZERO);
                data_q  <= sel_is_mdu ? mdu_data : sel_data;
            end else if ((state_q == ST_WAIT_MDU) && mdu_valid && !flush) begin
                data_q  <= mdu_data;
            end
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_waddr = waddr_q;
    assign out_wen   = wen_q;
    assign busy      = (state_q == ST_WAIT_MDU);
    assign stall_cnt = stall_q;

`ifdef WB_RESULT_BYPASS_EN
    assign fwd_valid = out_valid && out_wen;
    assign fwd_data  = out_data;
`else
    // No forward path in this build.
`endif

endmodule

// File: tb/tb_wb_result_stage.sv
module tb_wb_result_stage;
    import pipe_pkg::*;

    localparam int DW   = 32;
    localparam int NSRC = 4;
    localparam int MDU  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NSRC-1:0]   in_sel;
    logic [NSRC*DW-1:0] in_data;
    logic [4:0]        in_waddr;
    logic              in_wen;
    logic              mdu_valid;
    logic [DW-1:0]     mdu_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [4:0]        out_waddr;
    logic              out_wen;
    logic              busy;
    logic [15:0]       stall_cnt;
`ifdef WB_RESULT_BYPASS_EN
    logic              fwd_valid;
    logic [DW-1:0]     fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_result_stage #(.DW(DW), .NSRC(NSRC), .MDU_IDX(MDU)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_waddr  (in_waddr),
        .in_wen    (in_wen),
        .mdu_valid (mdu_valid),
        .mdu_data  (mdu_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_waddr (out_waddr),
        .out_wen   (out_wen),
        .busy      (busy),
        .stall_cnt (stall_cnt)
`ifdef WB_RESULT_BYPASS_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_data  (fwd_data)
`endif
    );

    // Reference model: a single result slot that is either empty, waiting
    // for the MDU, or holding a finished bundle.
    bit          m_full;
    bit          m_wait;
    logic [31:0] m_data;
    logic [4:0]  m_waddr;
    bit          m_wen;
    int          m_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (!m_full && !m_wait) || (m_full && out_ready);
    endfunction

    function automatic int winner(input logic [NSRC-1:0] s);
        for (int i = 0; i < NSRC; i++) begin
            if (s[i]) return i;
        end
        return NSRC - 1;
    endfunction

    task automatic model_update();
        bit rdy;
        bit acc;
        int w;
        rdy = model_ready();
        if (!rst_n) begin
            m_full = 0; m_wait = 0; m_data = '0; m_waddr = '0; m_wen = 0; m_stall = 0;
            return;
        end
        if (in_valid && !rdy && m_stall < 65535) m_stall++;
        if (flush) begin
            m_full = 0;
            m_wait = 0;
            return;
        end
        acc = in_valid && rdy;
        if (m_wait) begin
            if (mdu_valid) begin
                m_data = mdu_data;
                m_wait = 0;
                m_full = 1;
            end
        end else if (m_full && out_ready && !acc) begin
            m_full = 0;
        end
        if (acc) begin
            w       = winner(in_sel);
            m_waddr = in_waddr;
            m_wen   = in_wen && (in_waddr != 5'd0);
            if (w == MDU) begin
                if (mdu_valid) begin
                    m_data = mdu_data; m_full = 1; m_wait = 0;
                end else begin
                    m_full = 0; m_wait = 1;
                end
            end else begin
                m_data = in_data[w*DW +: DW];
                m_full = 1;
                m_wait = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("in_ready", {63'd0, in_ready}, {63'd0, model_ready()});
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_full});
        chk("busy", {63'd0, busy}, {63'd0, m_wait});
        chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
        if (m_full) begin
            chk("out_data", {32'd0, out_data}, {32'd0, m_data});
            chk("out_waddr", {59'd0, out_waddr}, {59'd0, m_waddr});
            chk("out_wen", {63'd0, out_wen}, {63'd0, m_wen});
        end
`ifdef WB_RESULT_BYPASS_EN
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, (m_full && m_wen)});
        if (m_full) chk("fwd_data", {32'd0, fwd_data}, {32'd0, m_data});
`endif
    endtask

    // Inputs are set after the previous edge; compare at negedge, then
    // advance the model at the posedge and return 1 time unit later.
    task automatic cycle(input bit do_chk = 1'b1);
        @(negedge clk);
        if (do_chk) check_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_src(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    typedef struct {
        logic [3:0]  sel;
        logic [4:0]  waddr;
        logic        wen;
        logic        mv;
        logic [31:0] exp_data;
        logic        exp_wen;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{4'b0101, 5'd5,  1'b1, 1'b0, 32'hDEAD0001, 1'b1};
        vecs[1] = '{4'b0010, 5'd7,  1'b1, 1'b0, 32'h11110001, 1'b1};
        vecs[2] = '{4'b1000, 5'd3,  1'b0, 1'b0, 32'h33330003, 1'b0};
        vecs[3] = '{4'b0000, 5'd9,  1'b1, 1'b0, 32'h33330003, 1'b1};
        vecs[4] = '{4'b0000, 5'd0,  1'b1, 1'b0, 32'h33330003, 1'b0};
        vecs[5] = '{4'b1100, 5'd4,  1'b1, 1'b1, 32'h5555AAAA, 1'b1};
        vecs[6] = '{4'b1010, 5'd31, 1'b1, 1'b0, 32'h11110001, 1'b1};

        rst_n = 1'b0; in_valid = 0; in_sel = '0; in_waddr = '0; in_wen = 0;
        mdu_valid = 0; mdu_data = '0; flush = 0; out_ready = 1;
        set_src(32'hDEAD0001, 32'h11110001, 32'h22220002, 32'h33330003);
        m_full = 0; m_wait = 0; m_data = '0; m_waddr = '0; m_wen = 0; m_stall = 0;

        @(posedge clk); #1;
        cycle(1'b0);
        cycle(1'b0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_waddr", {59'd0, out_waddr}, 64'd0);
        chk("rst_out_wen", {63'd0, out_wen}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_stall", {48'd0, stall_cnt}, 64'd0);
        rst_n = 1'b1;
        cycle();

        // Table-driven single requests from IDLE.
        mdu_data = 32'h5555AAAA;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1; in_sel = vecs[i].sel; in_waddr = vecs[i].waddr;
            in_wen = vecs[i].wen; mdu_valid = vecs[i].mv;
            cycle();
            in_valid = 0; mdu_valid = 0;
            chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("vec%0d_data", i), {32'd0, out_data}, {32'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d_wen", i), {63'd0, out_wen}, {63'd0, vecs[i].exp_wen});
            cycle();
        end

        // MDU late by 3 cycles with the request held upstream.
        in_valid = 1; in_sel = 4'b0100; in_waddr = 5'd12; in_wen = 1;
        mdu_valid = 0; out_ready = 0; mdu_data = 32'h00C0FFEE;
        cycle();
        in_sel = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mdu_busy%0d", k), {63'd0, busy}, 64'd1);
            chk($sformatf("mdu_ready%0d", k), {63'd0, in_ready}, 64'd0);
            mdu_valid = (k == 2);
            cycle();
        end
        mdu_valid = 0;
        chk("mdu_stall3", {48'd0, stall_cnt}, 64'd3);
        chk("mdu_data", {32'd0, out_data}, 64'h00C0FFEE);
        chk("mdu_valid_out", {63'd0, out_valid}, 64'd1);

        // Backpressure for 4 cycles, then back-to-back accept.
        begin
            logic [31:0] held;
            held = out_data;
            for (int k = 0; k < 4; k++) begin
                cycle();
                chk("bp_stable", {32'd0, out_data}, {32'd0, held});
                chk("bp_ready0", {63'd0, in_ready}, 64'd0);
            end
        end
        out_ready = 1;
        set_src(32'h12345678, 32'h11110001, 32'h22220002, 32'h33330003);
        cycle();
        in_valid = 0;
        chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        chk("b2b_data", {32'd0, out_data}, 64'h12345678);
        cycle();
        cycle();

        // Flush while waiting for the MDU.
        in_valid = 1; in_sel = 4'b0100; mdu_valid = 0;
        cycle();
        in_valid = 0; flush = 1;
        cycle();
        flush = 0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        mdu_valid = 1;
        cycle();
        mdu_valid = 0;
        chk("flush_late_mdu", {63'd0, out_valid}, 64'd0);
        cycle();

        // Reset while waiting for the MDU.
        in_valid = 1; in_sel = 4'b0100;
        cycle();
        in_valid = 0; rst_n = 0;
        cycle();
        rst_n = 1; mdu_valid = 1;
        cycle();
        mdu_valid = 0;
        chk("rst_late_mdu", {63'd0, out_valid}, 64'd0);
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_sel    = 4'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_waddr  = 5'($urandom);
            in_wen    = ($urandom_range(0, 99) < 80);
            mdu_valid = ($urandom_range(0, 99) < 30);
            mdu_data  = $urandom;
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            rst_n     = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1; flush = 0; in_valid = 0; mdu_valid = 0; out_ready = 1;
        cycle();

        // Long stall to saturation, then reset.
        in_valid = 1; in_sel = 4'b0100; in_waddr = 5'd1; in_wen = 1;
        cycle();
        for (int n = 0; n < 70000; n++) cycle(1'b0);
        chk("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
        cycle();
        chk("stall_sat_hold", {48'd0, stall_cnt}, 64'hFFFF);
        rst_n = 0; in_valid = 0;
        cycle(1'b0);
        chk("final_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("final_rst_data", {32'd0, out_data}, 64'd0);
        chk("final_rst_waddr", {59'd0, out_waddr}, 64'd0);
        chk("final_rst_wen", {63'd0, out_wen}, 64'd0);
        chk("final_rst_busy", {63'd0, busy}, 64'd0);
        chk("final_rst_stall", {48'd0, stall_cnt}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_result_stage.md
WB_RESULT_STAGE -- requirements
Module: wb_result_stage

Interface
REQ-001 Parameter DW, default 32: datapath width.
REQ-002 Parameter NSRC, default 4: number of result sources, minimum 2.
REQ-003 Parameter MDU_IDX, default 2: index of the multi-cycle source, range 0..NSRC-1.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1: reset; synchronous, active-low.
REQ-006 Port in_valid, input, 1: upstream result request valid.
REQ-007 Port in_ready, output, 1: stage can accept a request this cycle.
REQ-008 Port in_sel, input, NSRC: source request bits; the lowest set index wins; all-zero selects index NSRC-1.
REQ-009 Port in_data, input, NSRC*DW: source i occupies bits [i*DW +: DW].
REQ-010 Port in_waddr, input, 5: destination register address.
REQ-011 Port in_wen, input, 1: register write enable.
REQ-012 Port mdu_valid and mdu_data, inputs, 1 and DW: late multi-cycle result and its strobe.
REQ-013 Port flush, input, 1: discard all held and incoming work.
REQ-014 Port out_valid, output, 1: registered result valid.
REQ-015 Port out_ready, input, 1: downstream accepts the result.
REQ-016 Port out_data, out_waddr and out_wen, outputs, DW, 5 and 1: registered writeback bundle.
REQ-017 Port busy, output, 1: high while waiting for the MDU.
REQ-018 Port stall_cnt, output, 16: count of cycles with in_valid=1 and in_ready=0.

Function
REQ-019 States: IDLE, WAIT_MDU, FULL; a request is accepted when in_valid=1 and in_ready=1.
REQ-020 in_ready=1 in IDLE; in FULL only when out_ready=1; 0 in WAIT_MDU.
REQ-021 Non-MDU source accepted: data, waddr and wen registered; next state FULL; out_valid one cycle after accept.
REQ-022 MDU source accepted with mdu_valid=1 in the same cycle: mdu_data is captured; next state FULL.
REQ-023 MDU source accepted with mdu_valid=0: waddr and wen are captured; next state WAIT_MDU; busy=1.
REQ-024 In WAIT_MDU, mdu_valid=1 captures mdu_data; next state FULL; mdu_valid in any other state is ignored.
REQ-025 In FULL, out_* remain stable until out_ready=1.
REQ-026 FULL with out_ready=1 and no accept: next state IDLE.
REQ-027 FULL with out_ready=1 and an accept in the same cycle: back-to-back, with no bubble; next state per REQ-021 to REQ-023.
REQ-028 out_wen is forced to 0 when out_waddr=0.
REQ-029 flush=1 has priority over every other input: next state IDLE, out_valid=0, busy=0, the same-cycle request is dropped; stall_cnt is unaffected.
REQ-030 stall_cnt increments each stall cycle, saturates at 16'hFFFF and does not wrap.

Reset
REQ-031 When rst_n=0 at a clock edge: state IDLE; out_valid, out_data, out_waddr, out_wen, busy and stall_cnt are 0.
REQ-032 Reset mid-WAIT_MDU abandons the pending result; a later mdu_valid is ignored.

Configuration
REQ-033 Macro WB_RESULT_BYPASS_EN defined: outputs fwd_valid (1) and fwd_data (DW) are present.
REQ-034 With the macro, fwd_valid=out_valid and out_wen, and fwd_data=out_data, both combinational, for the ID-stage forward path.
REQ-035 Macro undefined: the fwd_* ports and their logic are absent; all other behaviour is identical.

Structure
REQ-036 Shared package pipe_pkg holds the state encoding typedef and the register-address width constant (5) and REG_ZERO.
REQ-037 Sub-module pri_src_sel (combinational priority index encoder plus data select, parametrised DW and NSRC) is instantiated once.

Verification
REQ-038 Source 0 selected (in_sel=4'b0101, data0=32'hDEAD0001, waddr=5): out_data=32'hDEAD0001 and out_wen=1 one cycle later.
REQ-039 MDU selected, mdu_valid after 3 cycles with 32'h00C0FFEE: busy=1 for 3 cycles, in_ready=0, stall_cnt=3 if in_valid is held, then out_data=32'h00C0FFEE.
REQ-040 out_ready=0 for 4 cycles in FULL: out_* stay constant and in_ready=0; the first cycle with out_ready=1 also accepts the next request with no bubble.
REQ-041 flush asserted in WAIT_MDU: next cycle is IDLE with busy=0; a later mdu_valid produces no out_valid.
REQ-042 waddr=0 with wen=1: out_wen=0. in_sel=0: source NSRC-1 is output.
REQ-043 Hold stall for 70000 cycles: stall_cnt=16'hFFFF. Apply rst_n=0: all outputs are 0 on the next edge.
